// File: rtl/reg_file_2r1w.sv
// reg_file_2r1w: parametrised register bank, one synchronous write port, two read ports.
// Rev 1.0
`default_nettype none

module reg_file_2r1w #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2,
  parameter int ZERO_REG   = 0,
  parameter int BYPASS     = 1,
  parameter int REG_READ   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] w_addr,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic [ADDR_WIDTH-1:0] ra_addr,
  input  logic [ADDR_WIDTH-1:0] rb_addr,
  output logic [DATA_WIDTH-1:0] ra_data,
  output logic [DATA_WIDTH-1:0] rb_data
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  write_ok;
  logic                  fwd_active;
  logic [DATA_WIDTH-1:0] ra_next;
  logic [DATA_WIDTH-1:0] rb_next;

  // Writes to the hardwired zero register are dropped before they reach storage.
  assign write_ok   = wr_en && !((ZERO_REG != 0) && (w_addr == '0));
  assign fwd_active = (BYPASS != 0) && wr_en && rst_n;

  genvar i;
  generate
    for (i = 0; i < DEPTH; i++) begin : g_mem
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          mem[i] <= '0;
        end else if (write_ok && (w_addr == ADDR_WIDTH'(i))) begin
          mem[i] <= w_data;
        end
      end
    end
  endgenerate

  // Zero-register check is applied last so it overrides forwarding.
  always_comb begin
    ra_next = mem[ra_addr];
    if (fwd_active && (ra_addr == w_addr)) begin
      ra_next = w_data;
    end
    if ((ZERO_REG != 0) && (ra_addr == '0)) begin
      ra_next = '0;
    end
  end

  always_comb begin
    rb_next = mem[rb_addr];
    if (fwd_active && (rb_addr == w_addr)) begin
      rb_next = w_data;
    end
    if ((ZERO_REG != 0) && (rb_addr == '0)) begin
      rb_next = '0;
    end
  end

  generate
    if (REG_READ != 0) begin : g_reg_read
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          ra_data <= '0;
          rb_data <= '0;
        end else begin
          ra_data <= ra_next;
          rb_data <= rb_next;
        end
      end
    end else begin : g_comb_read
      assign ra_data = ra_next;
      assign rb_data = rb_next;
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_reg_file_2r1w.sv
// tb_reg_file_2r1w: directed checks of reg_file_2r1w in four parameter configurations.
// Rev 1.0
`default_nettype none

module tb_reg_file_2r1w;

  logic clk;
  logic rst_n;

  // Default and no-bypass instances share stimulus
  logic       wr_en;
  logic [1:0] w_addr;
  logic [7:0] w_data;
  logic [1:0] ra_addr;
  logic [1:0] rb_addr;
  logic [7:0] def_ra, def_rb, nb_ra, nb_rb;

  logic       z_wr_en;
  logic [1:0] z_w_addr;
  logic [7:0] z_w_data;
  logic [1:0] z_ra_addr;
  logic [1:0] z_rb_addr;
  logic [7:0] z_ra, z_rb;

  logic        r_wr_en;
  logic [3:0]  r_w_addr;
  logic [15:0] r_w_data;
  logic [3:0]  r_ra_addr;
  logic [3:0]  r_rb_addr;
  logic [15:0] r_ra, r_rb;

  int checks = 0;
  int errors = 0;

  reg_file_2r1w u_def (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .w_addr(w_addr), .w_data(w_data),
    .ra_addr(ra_addr), .rb_addr(rb_addr), .ra_data(def_ra), .rb_data(def_rb)
  );

  reg_file_2r1w #(.BYPASS(0)) u_nb (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .w_addr(w_addr), .w_data(w_data),
    .ra_addr(ra_addr), .rb_addr(rb_addr), .ra_data(nb_ra), .rb_data(nb_rb)
  );

  reg_file_2r1w #(.ZERO_REG(1)) u_zr (
    .clk(clk), .rst_n(rst_n), .wr_en(z_wr_en), .w_addr(z_w_addr), .w_data(z_w_data),
    .ra_addr(z_ra_addr), .rb_addr(z_rb_addr), .ra_data(z_ra), .rb_data(z_rb)
  );

  reg_file_2r1w #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .REG_READ(1)) u_rr (
    .clk(clk), .rst_n(rst_n), .wr_en(r_wr_en), .w_addr(r_w_addr), .w_data(r_w_data),
    .ra_addr(r_ra_addr), .rb_addr(r_rb_addr), .ra_data(r_ra), .rb_data(r_rb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    wr_en = 1'b0; w_addr = '0; w_data = '0; ra_addr = '0; rb_addr = '0;
    z_wr_en = 1'b0; z_w_addr = '0; z_w_data = '0; z_ra_addr = '0; z_rb_addr = '0;
    r_wr_en = 1'b0; r_w_addr = '0; r_w_data = '0; r_ra_addr = '0; r_rb_addr = '0;

    // Two reset clocks, then sweep every address
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ra_addr = 2'(i);
      rb_addr = 2'(3 - i);
      #1;
      check("reset_ra", {8'h0, def_ra}, 16'h0000);
      check("reset_rb", {8'h0, def_rb}, 16'h0000);
    end
    check("reset_rr_ra", r_ra, 16'h0000);

    // Write coincident with reset is lost
    rst_n = 1'b0; wr_en = 1'b1; w_addr = 2'd1; w_data = 8'h55;
    tick();
    rst_n = 1'b1; wr_en = 1'b0; ra_addr = 2'd1;
    #1;
    check("reset_beats_write", {8'h0, def_ra}, 16'h0000);

    // Fill 100,101,110,120
    wr_en = 1'b1;
    w_addr = 2'd0; w_data = 8'd100; tick();
    w_addr = 2'd1; w_data = 8'd101; tick();
    w_addr = 2'd2; w_data = 8'd110; tick();
    w_addr = 2'd3; w_data = 8'd120; tick();
    wr_en = 1'b0;
    ra_addr = 2'd2; rb_addr = 2'd0;
    #1;
    check("fill_ra2", {8'h0, def_ra}, 16'd110);
    check("fill_rb0", {8'h0, def_rb}, 16'd100);
    check("fill_nb_ra2", {8'h0, nb_ra}, 16'd110);
    ra_addr = 2'd3; rb_addr = 2'd3;
    #1;
    check("same_addr_ra", {8'h0, def_ra}, 16'd120);
    check("same_addr_rb", {8'h0, def_rb}, 16'd120);

    // Same-cycle write/read of addr 1
    ra_addr = 2'd1; rb_addr = 2'd0;
    wr_en = 1'b1; w_addr = 2'd1; w_data = 8'hAA;
    #1;
    check("bypass_pre", {8'h0, def_ra}, 16'h00AA);
    check("nobypass_pre", {8'h0, nb_ra}, 16'd101);
    check("nobypass_other", {8'h0, nb_rb}, 16'd100);
    tick();
    wr_en = 1'b0;
    #1;
    check("bypass_post", {8'h0, def_ra}, 16'h00AA);
    check("nobypass_post", {8'h0, nb_ra}, 16'h00AA);

    // Mid-sequence reset discards everything
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ra_addr = 2'(i);
      rb_addr = 2'(i);
      #1;
      check("midreset_ra", {8'h0, def_ra}, 16'h0000);
      check("midreset_nb_rb", {8'h0, nb_rb}, 16'h0000);
    end
    wr_en = 1'b1; w_addr = 2'd3; w_data = 8'h12;
    tick();
    wr_en = 1'b0; ra_addr = 2'd3;
    #1;
    check("after_reset_write", {8'h0, def_ra}, 16'h0012);

    // Zero register
    z_wr_en = 1'b1; z_w_addr = 2'd0; z_w_data = 8'h7F; tick();
    z_w_addr = 2'd2; z_w_data = 8'h33; tick();
    z_wr_en = 1'b0; z_ra_addr = 2'd0; z_rb_addr = 2'd2;
    #1;
    check("zero_ra0", {8'h0, z_ra}, 16'h0000);
    check("zero_rb2", {8'h0, z_rb}, 16'h0033);
    z_wr_en = 1'b1; z_w_addr = 2'd0; z_w_data = 8'h5A; z_rb_addr = 2'd0;
    #1;
    check("zero_over_bypass", {8'h0, z_ra}, 16'h0000);
    check("zero_over_bypass_b", {8'h0, z_rb}, 16'h0000);
    tick();
    z_wr_en = 1'b0;
    #1;
    check("zero_after_write", {8'h0, z_ra}, 16'h0000);

    // Registered read: one-cycle latency
    r_wr_en = 1'b1; r_w_addr = 4'd9; r_w_data = 16'hBEEF;
    tick();
    r_wr_en = 1'b0; r_ra_addr = 4'd9;
    #1;
    check("rr_cycle_n", r_ra, 16'h0000);
    tick();
    check("rr_cycle_n1", r_ra, 16'hBEEF);
    r_wr_en = 1'b1; r_w_addr = 4'd9; r_w_data = 16'h1234; r_rb_addr = 4'd9;
    #1;
    check("rr_hold_before_edge", r_rb, 16'h0000);
    tick();
    r_wr_en = 1'b0;
    check("rr_fwd_ra", r_ra, 16'h1234);
    check("rr_fwd_rb", r_rb, 16'h1234);
    rst_n = 1'b0;
    tick();
    check("rr_reset_ra", r_ra, 16'h0000);
    check("rr_reset_rb", r_rb, 16'h0000);
    rst_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/reg_file_2r1w.md
Name: reg_file_2r1w

Overview:
- Parametrised successor to the 4x8 single-port register file.
- One synchronous write port and two independent read ports.
- Configurable width and depth, optional hardwired zero register, optional write-to-read bypass, optional registered (1-cycle) read outputs.
- Intended as the operand register bank for the datapath exercises: two source reads and one destination write per cycle.

Parameters:
- DATA_WIDTH, 8: bits per register.
- ADDR_WIDTH, 2: address bits; DEPTH = 2**ADDR_WIDTH registers.
- ZERO_REG, 0: when 1, register 0 always reads 0 and writes to it are discarded.
- BYPASS, 1: when 1, a read of the address being written this cycle returns w_data instead of stored data.
- REG_READ, 0: 0 = combinational read data; 1 = read data registered, valid one clk after address.

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk edge.
- wr_en  input  1  write enable.
- w_addr  input  ADDR_WIDTH  write address.
- w_data  input  DATA_WIDTH  write data.
- ra_addr  input  ADDR_WIDTH  read port A address.
- rb_addr  input  ADDR_WIDTH  read port B address.
- ra_data  output  DATA_WIDTH  read port A data.
- rb_data  output  DATA_WIDTH  read port B data.

Behaviour:
- Storage: DEPTH x DATA_WIDTH flops, no memory macro.
- Reset:
  - rst_n=0 at a rising edge clears every register to 0.
  - When REG_READ=1, the ra_data/rb_data output registers also clear to 0.
  - Reset wins over a simultaneous wr_en=1; that write is lost.
  - Reset asserted mid-sequence discards all prior writes.
- Write:
  - On rising edge with rst_n=1 and wr_en=1, mem[w_addr] <= w_data.
  - wr_en=0: no state change.
  - ZERO_REG=1 and w_addr=0: write ignored; mem[0] stays 0.
- Read, REG_READ=0:
  - ra_data = f(ra_addr), combinational; same for port B.
  - f(a) = 0 if ZERO_REG=1 and a=0.
  - Otherwise f(a) = w_data if BYPASS=1, wr_en=1, rst_n=1 and a=w_addr.
  - Otherwise f(a) = mem[a].
  - BYPASS=0: a same-address read returns the old value until after the edge.
- Read, REG_READ=1:
  - On each rising edge with rst_n=1, ra_data <= f(ra_addr) and rb_data <= f(rb_addr), using the pre-edge values of mem and the inputs.
  - Latency: address presented in cycle N -> data visible after edge N, i.e. during cycle N+1.
  - With BYPASS=1, a same-cycle write is forwarded into the output register.
  - With BYPASS=0, the old value is captured.
- Both ports may address the same register simultaneously; both return identical data.
- Zero-register priority: the ZERO_REG check takes precedence over bypass. w_addr=0 with ra_addr=0 reads 0.
- Addresses wrap naturally within ADDR_WIDTH. No out-of-range condition exists.
- No X propagation: every register has a defined value after the first reset edge. Outputs before the first reset are don't-care.

Test Plan:
- Reset then readback (defaults): rst_n=0 for 2 clks, then sweep ra_addr/rb_addr 0..3 -> all reads 0. Separately, write 0x55 to addr 1 in the same edge as rst_n=0 -> addr 1 reads 0.
- Fill and dual read (defaults): write 100,101,110,120 to addrs 0..3 on successive clks, wr_en=0. Then ra_addr=2, rb_addr=0 -> ra_data=110, rb_data=100. Then ra=rb=3 -> both read 120.
- Bypass (BYPASS=1, REG_READ=0): mem[1]=101. In one cycle wr_en=1, w_addr=1, w_data=0xAA, ra_addr=1 -> ra_data=0xAA before the edge, 0xAA after. With BYPASS=0 the same stimulus -> 101 before the edge, 0xAA after.
- Zero register (ZERO_REG=1): write 0x7F to addr 0, then 0x33 to addr 2. Read ra=0, rb=2 -> 0 and 0x33. Same-cycle write/read of addr 0 -> 0.
- Registered read (REG_READ=1, DATA_WIDTH=16, ADDR_WIDTH=4):
  - Write 0xBEEF to addr 9.
  - Set ra_addr=9 in cycle N -> ra_data still holds the prior value in cycle N and is 0xBEEF from cycle N+1.
  - rst_n=0 -> ra_data=0 after the edge.
- Mid-operation reset: after the fill sequence, assert rst_n=0 for one clk, then read all addrs -> 0. Then write 0x12 to addr 3 -> reads 0x12.
